i2c_target_regfile: RTL
=======================

Name: i2c_target_regfile

Overview:
Synthesizable, parametrised I2C target (slave) that oversamples SCL/SDA on the system clock and fronts an internal byte-wide register file. It generalises the codec bus-model protocol into hardware:
- configurable device address;
- multi-byte register pointer;
- auto-incrementing burst reads and writes;
- repeated-START support;
- address-mismatch NACK.

It sits behind the board-level open-drain pads and gives fabric logic a write-notify strobe and a side read port.

Parameters:
DEV_ADDR, 7'h1A, 7-bit target address matched against the first byte after START.
DEPTH, 16, number of 8-bit registers (2..65536); need not be a power of two.
PTR_BYTES, 1, register-pointer bytes sent by the controller after a write address (1 or 2, MSB first).
SYNC_STAGES, 2, synchroniser flops on scl_i/sda_i (>=2).
HOLD_CYC, 4, clk cycles after the synchronised SCL falling edge before sda_oe may change.

Ports:
clk  in  1  system clock; must be >= 16x SCL.
rst  in  1  asynchronous, active-high reset.
scl_i  in  1  raw SCL pad input.
sda_i  in  1  raw SDA pad input.
sda_oe  out  1  1 = pull SDA low; 0 = release (pad is open-drain).
wr_stb  out  1  one-cycle pulse when a data byte is committed to the register file.
wr_addr  out  $clog2(DEPTH)  register index of the committed byte.
wr_data  out  8  committed byte.
host_raddr  in  $clog2(DEPTH)  fabric read index.
host_rdata  out  8  regs[host_raddr], combinational.
busy  out  1  high from START until STOP or return to IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - sda_oe=0, wr_stb=0, wr_addr=0, wr_data=0, busy=0.
  - All registers = 8'h00, pointer = 0, state = IDLE.
  - Asserting rst mid-transfer releases SDA within the same cycle.
- Input sampling:
  - scl_i and sda_i each pass through SYNC_STAGES flops.
  - Edge detect uses the last two synchronised samples.
- Bus events:
  - START: sync SDA 1->0 while sync SCL=1.
  - STOP: sync SDA 0->1 while sync SCL=1.
  - Both are recognised in every state.
  - START mid-transfer is a repeated START: go to ADDR, keep the pointer.
  - STOP in any state: go to IDLE, release SDA, busy=0 next cycle.
- Bit timing:
  - Shift-in on the sync SCL rising edge.
  - All sda_oe changes occur exactly HOLD_CYC clks after the sync SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- IDLE -> ADDR on START; busy=1.
- ADDR: shift 8 bits. On the 8th falling edge:
  - If byte[7:1]==DEV_ADDR, go to ADDR_ACK and drive low.
  - Otherwise go to IGNORE with SDA released (NACK).
- ADDR_ACK, released at the next falling edge:
  - R/W=0 -> PTR with ptr_cnt=0.
  - R/W=1 -> RDATA; load shifter with regs[ptr], MSB driven at that same falling edge.
- PTR: accumulate pointer MSB first over PTR_BYTES bytes, ACKing each via PTR_ACK.
  - Pointer width is 8*PTR_BYTES internally.
  - Value >= DEPTH: NACK the final pointer byte, then IGNORE.
  - After the last byte -> WDATA.
- WDATA: on the 8th rising edge, regs[ptr] <= byte, and wr_stb/wr_addr/wr_data pulse for one clk. Then WDATA_ACK (ACK).
  - After the ACK, pointer increments, wrapping DEPTH-1 -> 0.
  - Return to WDATA.
- RDATA: shift out regs[ptr], MSB first.
  - Bit value 0 drives low; bit value 1 releases.
  - After 8 bits -> RDATA_ACK with SDA released.
- RDATA_ACK: sample the controller's bit on the rising edge.
  - ACK (0): pointer++ with wrap, reload the shifter, go to RDATA.
  - NACK (1): go to IGNORE.
- IGNORE: SDA released; wait for START or STOP.
- Pointer retention:
  - The pointer persists across transactions until reset.
  - A read immediately after STOP continues from the last pointer.
- Collision: the host read port and wr_stb may coincide; host_rdata reflects the new value the cycle after the write.
- General-call (address 0) is not supported and is NACKed.

Test Plan:
- Write with defaults: START, 0x34, 0x05, 0xA5, 0x3C, STOP -> ACK on every byte.
  - wr_stb pulses twice: (5,0xA5), then (6,0x3C).
  - host_rdata at index 6 = 0x3C.
  - busy drops after STOP.
- Combined read: START, 0x34, 0x05, repeated START, 0x35, read 3 bytes ACK/ACK/NACK, STOP.
  - Returns 0xA5, 0x3C, 0x00.
  - No wr_stb.
  - sda_oe=0 after the NACK.
- Wrap: write pointer 0x0F, data 0x11, 0x22 -> regs[15]=0x11, regs[0]=0x22.
- Address mismatch: START, 0x36 -> SDA released at the ACK slot.
  - Following bytes are ignored; no wr_stb.
  - busy clears on STOP.
- Range and width checks:
  - DEPTH=16: pointer 0x20 -> NACK.
  - DEPTH=300, PTR_BYTES=2: pointer 0x01,0x2B then data 0x77 -> wr_addr=299; next byte wraps to index 0.
- Reset mid-read: assert rst while the target drives a 0 bit -> sda_oe=0 asynchronously, and all outputs hold their reset values.
  - Next transaction: START, 0x35, read one byte (NACK), STOP -> returns 0x00 from pointer 0.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: oversampled I2C target fronting a byte-wide register file
// with a multi-byte pointer, auto-incrementing bursts, repeated START and address NACK.
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int DEPTH = 16,
  parameter int PTR_BYTES = 1,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYC = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = 8 * PTR_BYTES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic [AW-1:0] host_raddr,
  output logic [7:0]    host_rdata,
  output logic          busy
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;
  state_t r_state, w_state;
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic r_scl_p, r_sda_p;
  logic [7:0] r_regs [DEPTH];
  logic [7:0] r_sh, w_sh, w_rd, w_rd_inc;
  logic [3:0] r_bit, w_bit;
  logic [AW-1:0] r_ptr, w_ptr, w_ptr_inc;
  logic [PW-1:0] r_pacc, w_pacc, w_pacc_new;
  logic [1:0] r_pcnt, w_pcnt;
  logic r_pend, w_pend, r_ack, w_ack, r_rw, w_rw, w_we;
  logic [15:0] r_hold;
  logic w_scl, w_sda, w_rise, w_fall, w_start, w_stop;

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];
  assign w_rise = w_scl & ~r_scl_p;
  assign w_fall = ~w_scl & r_scl_p;
  assign w_start = w_scl & r_scl_p & r_sda_p & ~w_sda;
  assign w_stop = w_scl & r_scl_p & ~r_sda_p & w_sda;
  assign w_ptr_inc = (32'(r_ptr) == DEPTH - 1) ? '0 : r_ptr + 1'b1;
  assign w_pacc_new = PW'({r_pacc, r_sh});
  assign w_rd = r_regs[r_ptr];
  assign w_rd_inc = r_regs[w_ptr_inc];
  assign host_rdata = (32'(host_raddr) < DEPTH) ? r_regs[host_raddr] : '0;
  assign busy = r_state != IDLE;

  // Bytes shift in on SCL rise; every state decision and the SDA value it wants
  // (r_pend) are taken on SCL fall, then applied HOLD_CYC clocks later.
  always_comb begin
    w_state = r_state;
    w_sh = r_sh;
    w_bit = r_bit;
    w_ptr = r_ptr;
    w_pacc = r_pacc;
    w_pcnt = r_pcnt;
    w_pend = r_pend;
    w_ack = r_ack;
    w_rw = r_rw;
    w_we = 1'b0;
    if (w_start) begin
      w_state = ADDR;
      w_bit = '0;
      w_pend = 1'b0;
    end else if (w_stop) begin
      w_state = IDLE;
      w_pend = 1'b0;
    end else if (w_rise) begin
      if (r_state inside {ADDR, PTR, WDATA}) begin
        w_sh = {r_sh[6:0], w_sda};
        w_bit = r_bit + 4'd1;
      end
      if (r_state == RDATA) w_bit = r_bit + 4'd1;
      if (r_state == RDATA_ACK) w_ack = w_sda;
      w_we = (r_state == WDATA) && (r_bit == 4'd7);
    end else if (w_fall) begin
      case (r_state)
        ADDR: if (r_bit == 4'd8) begin
          w_bit = '0;
          w_rw = r_sh[0];
          w_state = (r_sh[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
          w_pend = r_sh[7:1] == DEV_ADDR;
        end
        ADDR_ACK: begin
          w_state = r_rw ? RDATA : PTR;
          w_sh = r_rw ? w_rd : r_sh;
          w_pend = r_rw & ~w_rd[7];
          w_pcnt = '0;
          w_pacc = '0;
        end
        PTR: if (r_bit == 4'd8) begin
          w_bit = '0;
          w_pcnt = r_pcnt + 2'd1;
          w_pacc = w_pacc_new;
          w_pend = 1'b1;
          w_state = PTR_ACK;
          if (32'(r_pcnt) == PTR_BYTES - 1) begin
            w_state = (32'(w_pacc_new) >= DEPTH) ? IGNORE : PTR_ACK;
            w_pend = 32'(w_pacc_new) < DEPTH;
            w_ptr = (32'(w_pacc_new) < DEPTH) ? AW'(w_pacc_new) : r_ptr;
          end
        end
        PTR_ACK: begin
          w_state = (32'(r_pcnt) == PTR_BYTES) ? WDATA : PTR;
          w_pend = 1'b0;
        end
        WDATA: if (r_bit == 4'd8) begin
          w_bit = '0;
          w_state = WDATA_ACK;
          w_pend = 1'b1;
        end
        WDATA_ACK: begin
          w_ptr = w_ptr_inc;
          w_state = WDATA;
          w_pend = 1'b0;
        end
        RDATA: begin
          w_state = (r_bit == 4'd8) ? RDATA_ACK : RDATA;
          w_bit = (r_bit == 4'd8) ? '0 : r_bit;
          w_sh = {r_sh[6:0], 1'b0};
          w_pend = (r_bit != 4'd8) & ~r_sh[6];
        end
        RDATA_ACK: begin
          w_state = r_ack ? IGNORE : RDATA;
          w_ptr = r_ack ? r_ptr : w_ptr_inc;
          w_sh = w_rd_inc;
          w_pend = ~r_ack & ~w_rd_inc[7];
          w_bit = '0;
        end
        default: w_pend = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_p <= 1'b1;
      r_sda_p <= 1'b1;
      r_state <= IDLE;
      r_sh <= '0;
      r_bit <= '0;
      r_ptr <= '0;
      r_pacc <= '0;
      r_pcnt <= '0;
      r_pend <= 1'b0;
      r_ack <= 1'b0;
      r_rw <= 1'b0;
      r_hold <= '0;
      sda_oe <= 1'b0;
      wr_stb <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_p <= w_scl;
      r_sda_p <= w_sda;
      r_state <= w_state;
      r_sh <= w_sh;
      r_bit <= w_bit;
      r_ptr <= w_ptr;
      r_pacc <= w_pacc;
      r_pcnt <= w_pcnt;
      r_pend <= w_pend;
      r_ack <= w_ack;
      r_rw <= w_rw;
      wr_stb <= w_we;
      if (w_we) begin
        r_regs[r_ptr] <= w_sh;
        wr_addr <= r_ptr;
        wr_data <= w_sh;
      end
      if (w_start || w_stop) begin
        sda_oe <= 1'b0;
        r_hold <= '0;
      end else if (w_fall) begin
        r_hold <= 16'(HOLD_CYC);
      end else if (r_hold != '0) begin
        r_hold <= r_hold - 16'd1;
        if (r_hold == 16'd1) sda_oe <= r_pend;
      end
    end
  end
endmodule
